store_drain_arbiter: RTL and testbench

- Holds committed stores in a small FIFO, the committed store buffer, and drains them to the single D-cache request port.
- Arbitrates that port between committed stores and speculative load issue from the memory pipe.
- Sits between the commit stage (which raises store_done with the store queue head's address and data) and the D-cache.
- Entries are architecturally committed: no flush ever removes them.

---
 rtl/store_drain_arbiter.sv | 137 +++++++++++++
 tb/tb_store_drain_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/store_drain_arbiter.sv
// Committed store buffer that drains to the single D-cache request port and
// shares that port with speculative loads (load priority, starvation/hazard/fence forcing).
module store_drain_arbiter #(
  parameter int SB_DEPTH     = 4,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              commit_store_valid,
  input  logic [ADDR_W-1:0] commit_store_addr,
  input  logic [DATA_W-1:0] commit_store_data,
  output logic              sb_full,
  output logic              sb_empty,
  input  logic              load_req_valid,
  input  logic [ADDR_W-1:0] load_req_addr,
  output logic              load_req_ready,
  input  logic              drain_req,
  output logic              cache_req_valid,
  output logic              cache_req_we,
  output logic [ADDR_W-1:0] cache_req_addr,
  output logic [DATA_W-1:0] cache_req_wdata,
  input  logic              cache_req_ready,
  output logic              overflow_err,
  output logic [1:0]        dbg_state
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_LOAD = 2'd0, S_STORE = 2'd1, S_DRAIN = 2'd2} state_t;

  logic [ADDR_W-1:0] sb_addr [SB_DEPTH];
  logic [DATA_W-1:0] sb_data [SB_DEPTH];
  logic [SB_DEPTH-1:0] sb_vld;
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  logic [SC_W-1:0]   starve_cnt, starve_nxt;
  state_t            state, state_nxt;
  logic              hazard, enq, load_sel, store_sel, load_hs, store_hs;

  assign sb_full   = (count == CNT_W'(SB_DEPTH));
  assign sb_empty  = (count == '0);
  assign enq       = commit_store_valid && !sb_full;
  assign dbg_state = state;

  // Word-granular match against every occupied entry; no forwarding, so a hit blocks the load.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (sb_vld[i] && (sb_addr[i][ADDR_W-1:2] == load_req_addr[ADDR_W-1:2])) hazard = 1'b1;
    end
    hazard = hazard && load_req_valid;
  end

  always_comb begin
    load_sel  = 1'b0;
    store_sel = 1'b0;
    case (state)
      S_LOAD: begin
        if (load_req_valid && !hazard) load_sel = 1'b1;
        else                           store_sel = !sb_empty;
      end
      S_STORE: store_sel = !sb_empty;
      S_DRAIN: store_sel = !sb_empty;
      default: store_sel = 1'b0;
    endcase

    cache_req_valid = load_sel || store_sel;
    cache_req_we    = store_sel;
    cache_req_addr  = '0;
    cache_req_wdata = '0;
    if (store_sel) begin
      cache_req_addr  = sb_addr[head];
      cache_req_wdata = sb_data[head];
    end else if (load_sel) begin
      cache_req_addr  = load_req_addr;
    end
    load_req_ready = load_sel && cache_req_ready;
    load_hs        = load_sel && cache_req_ready;
    store_hs       = store_sel && cache_req_ready;

    starve_nxt = starve_cnt;
    if (store_hs || sb_empty)                              starve_nxt = '0;
    else if (load_hs && starve_cnt != SC_W'(STARVE_LIMIT)) starve_nxt = starve_cnt + 1'b1;

    // The starvation test uses the post-update count so the store follows the limiting load directly.
    state_nxt = state;
    case (state)
      S_LOAD:  if (sb_full || starve_nxt == SC_W'(STARVE_LIMIT) || hazard) state_nxt = S_STORE;
      S_STORE: if (store_hs || sb_empty) state_nxt = S_LOAD;
      S_DRAIN: if (sb_empty && !drain_req) state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
    if (drain_req) state_nxt = S_DRAIN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_LOAD;
      starve_cnt   <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      sb_vld       <= '0;
      overflow_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      if (commit_store_valid && sb_full) overflow_err <= 1'b1;
      if (store_hs) begin
        sb_vld[head] <= 1'b0;
        head         <= head + 1'b1;
      end
      if (enq) begin
        sb_vld[tail] <= 1'b1;
        tail         <= tail + 1'b1;
      end
      case ({enq, store_hs})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: occupancy is tracked by sb_vld/count.
  always_ff @(posedge clk) begin
    if (enq) begin
      sb_addr[tail] <= commit_store_addr;
      sb_data[tail] <= commit_store_data;
    end
  end

endmodule

// File: tb/tb_store_drain_arbiter.sv
// Bench for store_drain_arbiter: cycle vectors with hand-derived expectations plus
// a store-order scoreboard fed from commits and checked on every store handshake.
module tb_store_drain_arbiter;

  logic        clk, rst_n;
  logic        commit_store_valid;
  logic [31:0] commit_store_addr, commit_store_data;
  logic        sb_full, sb_empty;
  logic        load_req_valid;
  logic [31:0] load_req_addr;
  logic        load_req_ready;
  logic        drain_req;
  logic        cache_req_valid, cache_req_we;
  logic [31:0] cache_req_addr, cache_req_wdata;
  logic        cache_req_ready;
  logic        overflow_err;
  logic [1:0]  dbg_state;

  store_drain_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .commit_store_valid(commit_store_valid), .commit_store_addr(commit_store_addr),
    .commit_store_data(commit_store_data), .sb_full(sb_full), .sb_empty(sb_empty),
    .load_req_valid(load_req_valid), .load_req_addr(load_req_addr),
    .load_req_ready(load_req_ready), .drain_req(drain_req),
    .cache_req_valid(cache_req_valid), .cache_req_we(cache_req_we),
    .cache_req_addr(cache_req_addr), .cache_req_wdata(cache_req_wdata),
    .cache_req_ready(cache_req_ready), .overflow_err(overflow_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic cv; logic [31:0] ca; logic [31:0] cd;
    logic lv; logic [31:0] la; logic dr; logic rdy;
    logic e_v; logic e_we; logic [31:0] e_a; logic e_lr; logic e_f; logic e_e; logic e_o;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] exp_q[$];
  int          cmp_cnt = 0;
  int          err_cnt = 0;

  function automatic vec_t mk(int cv, int ca, int cd, int lv, int la, int dr, int rdy,
                              int ev, int ewe, int ea, int elr, int ef, int ee, int eo);
    vec_t r;
    r.cv = 1'(cv); r.ca = 32'(ca); r.cd = 32'(cd);
    r.lv = 1'(lv); r.la = 32'(la); r.dr = 1'(dr); r.rdy = 1'(rdy);
    r.e_v = 1'(ev); r.e_we = 1'(ewe); r.e_a = 32'(ea); r.e_lr = 1'(elr);
    r.e_f = 1'(ef); r.e_e = 1'(ee); r.e_o = 1'(eo);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: inputs at negedge, outputs checked 1 time unit later
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    commit_store_valid = v.cv; commit_store_addr = v.ca; commit_store_data = v.cd;
    load_req_valid = v.lv; load_req_addr = v.la; drain_req = v.dr; cache_req_ready = v.rdy;
    #1;
    chk($sformatf("v%0d_valid", idx), 64'(cache_req_valid), 64'(v.e_v));
    chk($sformatf("v%0d_we", idx), 64'(cache_req_we), 64'(v.e_we));
    chk($sformatf("v%0d_addr", idx), 64'(cache_req_addr), 64'(v.e_a));
    chk($sformatf("v%0d_load_ready", idx), 64'(load_req_ready), 64'(v.e_lr));
    chk($sformatf("v%0d_full", idx), 64'(sb_full), 64'(v.e_f));
    chk($sformatf("v%0d_empty", idx), 64'(sb_empty), 64'(v.e_e));
    chk($sformatf("v%0d_overflow", idx), 64'(overflow_err), 64'(v.e_o));
    if (!(cache_req_valid && cache_req_we))
      chk($sformatf("v%0d_wdata_zero", idx), 64'(cache_req_wdata), 64'd0);
    // scoreboard: every store handshake must match the oldest accepted commit
    if (cache_req_valid && cache_req_we && cache_req_ready) begin
      if (exp_q.size() == 0) chk($sformatf("v%0d_sb_underflow", idx), 64'd1, 64'd0);
      else chk($sformatf("v%0d_store_order", idx), {cache_req_addr, cache_req_wdata}, exp_q.pop_front());
    end
    if (v.cv && !v.e_f) exp_q.push_back({v.ca, v.cd});
  endtask

  initial begin
    rst_n = 1'b1;
    commit_store_valid = 0; commit_store_addr = 0; commit_store_data = 0;
    load_req_valid = 0; load_req_addr = 0; drain_req = 0; cache_req_ready = 0;

    // asynchronous reset asserted mid-cycle
    #3 rst_n = 1'b0;
    #1;
    chk("rst_empty", 64'(sb_empty), 64'd1);
    chk("rst_full", 64'(sb_full), 64'd0);
    chk("rst_valid", 64'(cache_req_valid), 64'd0);
    chk("rst_overflow", 64'(overflow_err), 64'd0);
    chk("rst_load_ready", 64'(load_req_ready), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // two stores, no loads
    vecs.push_back(mk(1,'h100,'hA, 0,0,0,1, 0,0,0,0,     0,1,0));
    vecs.push_back(mk(1,'h104,'hB, 0,0,0,1, 1,1,'h100,0, 0,0,0));
    vecs.push_back(mk(0,0,0,       0,0,0,1, 1,1,'h104,0, 0,0,0));
    vecs.push_back(mk(0,0,0,       0,0,0,1, 0,0,0,0,     0,1,0));
    // fill under continuous loads: full forces one store, then starvation forces another
    vecs.push_back(mk(1,'h100,1, 1,'h200,0,1, 1,0,'h200,1, 0,1,0));
    vecs.push_back(mk(1,'h104,2, 1,'h200,0,1, 1,0,'h200,1, 0,0,0));
    vecs.push_back(mk(1,'h108,3, 1,'h200,0,1, 1,0,'h200,1, 0,0,0));
    vecs.push_back(mk(1,'h10C,4, 1,'h200,0,1, 1,0,'h200,1, 0,0,0));
    vecs.push_back(mk(0,0,0,     1,'h200,0,1, 1,0,'h200,1, 1,0,0));
    vecs.push_back(mk(0,0,0,     1,'h200,0,1, 1,1,'h100,0, 1,0,0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0,0,0,   1,'h200,0,1, 1,0,'h200,1, 0,0,0));
    vecs.push_back(mk(0,0,0,     1,'h200,0,1, 1,1,'h104,0, 0,0,0));
    vecs.push_back(mk(0,0,0,     1,'h200,0,1, 1,0,'h200,1, 0,0,0));
    vecs.push_back(mk(0,0,0,     0,0,0,1,     1,1,'h108,0, 0,0,0));
    vecs.push_back(mk(0,0,0,     0,0,0,1,     1,1,'h10C,0, 0,0,0));
    vecs.push_back(mk(0,0,0,     0,0,0,1,     0,0,0,0,     0,1,0));
    // load to 0x302 blocked by buffered 0x300 until that write handshakes
    vecs.push_back(mk(1,'h300,'h33, 0,0,0,0,      0,0,0,0,     0,1,0));
    vecs.push_back(mk(0,0,0,        1,'h302,0,0,  1,1,'h300,0, 0,0,0));
    vecs.push_back(mk(0,0,0,        1,'h302,0,0,  1,1,'h300,0, 0,0,0));
    vecs.push_back(mk(0,0,0,        1,'h302,0,1,  1,1,'h300,0, 0,0,0));
    vecs.push_back(mk(0,0,0,        1,'h302,0,1,  1,0,'h302,1, 0,1,0));
    // one buffered store forced after four load grants, twice
    for (int k = 0; k < 2; k++) begin
      vecs.push_back(mk(1,'h400+4*k,'h44+k, 1,'h500,0,1, 1,0,'h500,1, 0,1,0));
      for (int i = 0; i < 4; i++)
        vecs.push_back(mk(0,0,0, 1,'h500,0,1, 1,0,'h500,1, 0,0,0));
      vecs.push_back(mk(0,0,0,   1,'h500,0,1, 1,1,'h400+4*k,0, 0,0,0));
    end
    vecs.push_back(mk(0,0,0, 0,0,0,1, 0,0,0,0, 0,1,0));
    // fence drain of three stores with ready 1,0,1,1
    vecs.push_back(mk(1,'h600,'h61, 0,0,0,0,     0,0,0,0,     0,1,0));
    vecs.push_back(mk(1,'h604,'h62, 0,0,0,0,     1,1,'h600,0, 0,0,0));
    vecs.push_back(mk(1,'h608,'h63, 0,0,0,0,     1,1,'h600,0, 0,0,0));
    vecs.push_back(mk(0,0,0,        0,0,1,0,     1,1,'h600,0, 0,0,0));
    vecs.push_back(mk(0,0,0,        1,'h700,1,1, 1,1,'h600,0, 0,0,0));
    vecs.push_back(mk(0,0,0,        1,'h700,1,0, 1,1,'h604,0, 0,0,0));
    vecs.push_back(mk(0,0,0,        1,'h700,1,1, 1,1,'h604,0, 0,0,0));
    vecs.push_back(mk(0,0,0,        1,'h700,1,1, 1,1,'h608,0, 0,0,0));
    vecs.push_back(mk(0,0,0,        1,'h700,1,1, 0,0,0,0,     0,1,0));
    vecs.push_back(mk(0,0,0,        1,'h700,0,1, 0,0,0,0,     0,1,0));
    vecs.push_back(mk(0,0,0,        1,'h700,0,1, 1,0,'h700,1, 0,1,0));
    vecs.push_back(mk(0,0,0,        0,0,0,1,     0,0,0,0,     0,1,0));
    // commit while full coincides with a store handshake: dropped, overflow sticks
    vecs.push_back(mk(1,'h800,'h81, 0,0,0,0, 0,0,0,0,     0,1,0));
    vecs.push_back(mk(1,'h804,'h82, 0,0,0,0, 1,1,'h800,0, 0,0,0));
    vecs.push_back(mk(1,'h808,'h83, 0,0,0,0, 1,1,'h800,0, 0,0,0));
    vecs.push_back(mk(1,'h80C,'h84, 0,0,0,0, 1,1,'h800,0, 0,0,0));
    vecs.push_back(mk(1,'h810,'h85, 0,0,0,1, 1,1,'h800,0, 1,0,0));
    vecs.push_back(mk(0,0,0,        0,0,0,1, 1,1,'h804,0, 0,0,1));
    vecs.push_back(mk(0,0,0,        0,0,0,1, 1,1,'h808,0, 0,0,1));
    vecs.push_back(mk(0,0,0,        0,0,0,1, 1,1,'h80C,0, 0,0,1));
    vecs.push_back(mk(0,0,0,        0,0,0,1, 0,0,0,0,     0,1,1));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // reset while draining discards buffered stores and clears overflow
    apply(mk(1,'h900,'h91, 0,0,0,0, 0,0,0,0,     0,1,1), 900);
    apply(mk(1,'h904,'h92, 0,0,0,0, 1,1,'h900,0, 0,0,1), 901);
    apply(mk(0,0,0,        0,0,1,0, 1,1,'h900,0, 0,0,1), 902);
    apply(mk(0,0,0,        0,0,1,0, 1,1,'h900,0, 0,0,1), 903);
    chk("drain_state_before_reset", 64'(dbg_state), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_empty", 64'(sb_empty), 64'd1);
    chk("midrst_valid", 64'(cache_req_valid), 64'd0);
    chk("midrst_overflow", 64'(overflow_err), 64'd0);
    chk("midrst_state", 64'(dbg_state), 64'd0);
    exp_q.delete();
    drain_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(0,0,0,        0,0,0,1, 0,0,0,0,     0,1,0), 910);
    apply(mk(0,0,0,        0,0,0,1, 0,0,0,0,     0,1,0), 911);
    apply(mk(1,'hA00,'hA1, 0,0,0,1, 0,0,0,0,     0,1,0), 912);
    apply(mk(0,0,0,        0,0,0,1, 1,1,'hA00,0, 0,0,0), 913);
    apply(mk(0,0,0,        0,0,0,1, 0,0,0,0,     0,1,0), 914);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
